// File: rtl/step_seeker_pkg.sv
// step_seeker_pkg: shared defaults, counter widths and FSM state encoding for step_seeker.
package step_seeker_pkg;
  localparam int WIDTH_DEF = 8;
  localparam int SETTLE_DEF = 2;
  localparam int MAX_CMDS_DEF = 32;
  localparam int CNT_W = 8;
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_CHECK,
    S_CMD,
    S_DONE,
    S_ERR
  } state_t;
endpackage

// File: rtl/step_seeker_calc.sv
// step_calc: direction, clamped step and equality between counter feedback and target.
module step_calc
  import step_seeker_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] max_step,
  output logic             dir,
  output logic             eq,
  output logic [WIDTH-1:0] step
);
  logic [WIDTH-1:0] w_dist;
  always_comb begin
    eq = q_in == target;
    dir = q_in < target;
    w_dist = dir ? target - q_in : q_in - target;
    step = w_dist < max_step ? w_dist : max_step;
  end
endmodule

// File: rtl/step_seeker.sv
// step_seeker: drives an up/down counter from a loaded start value to a target in bounded steps.
module step_seeker
  import step_seeker_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SETTLE = SETTLE_DEF,
  parameter int MAX_CMDS = MAX_CMDS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] init,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] max_step,
  input  logic [WIDTH-1:0] q_in,
  output logic             load,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic             up,
  output logic             dn,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] cmd_count
);
  localparam int WW = $clog2(SETTLE + 1);
  state_t           r_state;
  logic [WIDTH-1:0] r_target;
  logic [WIDTH-1:0] r_max_step;
  logic [WW-1:0]    r_wait;
  logic             w_dir;
  logic             w_eq;
  logic [WIDTH-1:0] w_step;

  step_calc #(.WIDTH(WIDTH)) u_calc (
    .q_in    (q_in),
    .target  (r_target),
    .max_step(r_max_step),
    .dir     (w_dir),
    .eq      (w_eq),
    .step    (w_step)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_target   <= '0;
      r_max_step <= '0;
      r_wait     <= '0;
      load       <= 1'b0;
      a_out      <= '0;
      b_out      <= '0;
      up         <= 1'b0;
      dn         <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      cmd_count  <= '0;
    end else begin
      load <= 1'b0;
      up   <= 1'b0;
      dn   <= 1'b0;
      done <= 1'b0;
      err  <= 1'b0;
      // Strobes are set on the transition into their state so they are high exactly during it.
      case (r_state)
        S_IDLE: if (start) begin
          r_target   <= target;
          r_max_step <= max_step;
          a_out      <= init;
          load       <= 1'b1;
          busy       <= 1'b1;
          cmd_count  <= '0;
          r_state    <= S_LOAD;
        end
        S_LOAD, S_CMD: begin
          r_wait  <= WW'(SETTLE - 1);
          r_state <= S_WAIT;
        end
        S_WAIT: if (r_wait == '0) r_state <= S_CHECK;
                else r_wait <= r_wait - 1'b1;
        S_CHECK: if (w_eq) begin
          done    <= 1'b1;
          r_state <= S_DONE;
        end else if (cmd_count == CNT_W'(MAX_CMDS) || r_max_step == '0) begin
          err     <= 1'b1;
          r_state <= S_ERR;
        end else begin
          up        <= w_dir;
          dn        <= !w_dir;
          b_out     <= w_step;
          cmd_count <= cmd_count + CNT_W'(cmd_count != '1);
          r_state   <= S_CMD;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_step_seeker.sv
// tb_step_seeker: randomized and directed checks of step_seeker against a counter model and a seek model.
module tb_step_seeker;
  import step_seeker_pkg::*;
  localparam int MAXC = 4;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, stuck = 1'b0;
  logic [7:0] init = '0, target = '0, max_step = '0, q_in;
  logic load, up, dn, busy, done, err;
  logic [7:0] a_out, b_out, cmd_count;
  logic [7:0] c_val = '0, c_q = '0;
  int checks = 0, errors = 0;
  int obs_steps[$], exp_steps[$];
  int obs_lat, obs_done, obs_err, exp_lat, exp_done, exp_cmds;
  bit obs_both, obs_busy0, obs_busy_after;
  logic [7:0] exp_q;

  always #5 clk = ~clk;
  assign q_in = stuck ? 8'd0 : c_q;

  // Counter with two-edge command-to-q latency; load acts as its reset/load.
  always @(posedge clk) begin
    if (load) c_val <= a_out;
    else if (up) c_val <= c_val + b_out;
    else if (dn) c_val <= c_val - b_out;
    c_q <= c_val;
  end

  step_seeker #(.WIDTH(8), .SETTLE(2), .MAX_CMDS(MAXC)) dut (
    .clk(clk), .rst(rst), .start(start), .init(init), .target(target),
    .max_step(max_step), .q_in(q_in), .load(load), .a_out(a_out), .b_out(b_out),
    .up(up), .dn(dn), .busy(busy), .done(done), .err(err), .cmd_count(cmd_count)
  );

  task automatic model(input logic [7:0] i, input logic [7:0] t, input logic [7:0] m);
    int q, n, d, s;
    q = int'(i);
    n = 0;
    exp_steps.delete();
    exp_done = 0;
    while (1) begin
      if (q == int'(t)) begin exp_done = 1; break; end
      if (n == MAXC || m == 0) break;
      d = q < int'(t) ? int'(t) - q : q - int'(t);
      s = d < int'(m) ? d : int'(m);
      exp_steps.push_back(q < int'(t) ? s : -s);
      q = q < int'(t) ? q + s : q - s;
      n++;
    end
    exp_cmds = n;
    exp_q = 8'(q);
    exp_lat = 4 + 4 * n;
  endtask

  function automatic bit same_steps();
    if (obs_steps.size() != exp_steps.size()) return 1'b0;
    foreach (obs_steps[k]) if (obs_steps[k] != exp_steps[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic run_op(input logic [7:0] i, input logic [7:0] t, input logic [7:0] m, input int poke);
    obs_steps.delete();
    obs_lat = -1; obs_done = 0; obs_err = 0; obs_both = 0; obs_busy_after = 1'b1;
    init = i; target = t; max_step = m; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    obs_busy0 = busy;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (c == poke) begin start = 1'b1; init = ~i; target = ~t; max_step = 8'd1; end
      if (up && dn) obs_both = 1'b1;
      if (up) obs_steps.push_back(int'(b_out));
      if (dn) obs_steps.push_back(-int'(b_out));
      if (done || err) begin
        obs_done = int'(done); obs_err = int'(err); obs_lat = c;
        @(posedge clk); #1;
        start = 1'b0;
        obs_busy_after = busy;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({load, up, dn, busy, done, err, a_out, b_out, cmd_count} !== '0) begin
      errors++; $display("FAIL reset_outputs got %h want 0", {load, up, dn, busy, done, err, a_out, b_out, cmd_count});
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_up_steps();
    model(8'd10, 8'd50, 8'd16);
    run_op(8'd10, 8'd50, 8'd16, -1);
    checks++; if (!same_steps()) begin errors++; $display("FAIL up_steps got %0d cmds want %0d", obs_steps.size(), exp_steps.size()); end
    checks++; if (obs_done !== 1) begin errors++; $display("FAIL up_done got %0d want 1", obs_done); end
    checks++; if (cmd_count !== 8'd3) begin errors++; $display("FAIL up_cmd_count got %0d want 3", cmd_count); end
    checks++; if (c_q !== 8'd50) begin errors++; $display("FAIL up_q got %0d want 50", c_q); end
    checks++; if (obs_busy0 !== 1'b1 || obs_busy_after !== 1'b0) begin errors++; $display("FAIL up_busy got %b%b want 10", obs_busy0, obs_busy_after); end
  endtask

  task automatic test_single_dn();
    model(8'd200, 8'd5, 8'd255);
    run_op(8'd200, 8'd5, 8'd255, -1);
    checks++; if (!same_steps() || obs_steps.size() != 1) begin errors++; $display("FAIL dn_steps got %0d cmds want 1", obs_steps.size()); end
    checks++; if (cmd_count !== 8'd1 || c_q !== 8'd5) begin errors++; $display("FAIL dn_result got cmd=%0d q=%0d want cmd=1 q=5", cmd_count, c_q); end
    checks++; if (obs_done !== 1) begin errors++; $display("FAIL dn_done got %0d want 1", obs_done); end
  endtask

  task automatic test_equal();
    run_op(8'd77, 8'd77, 8'd4, -1);
    checks++; if (obs_steps.size() != 0) begin errors++; $display("FAIL eq_cmds got %0d want 0", obs_steps.size()); end
    checks++; if (obs_lat != 4 || obs_done != 1) begin errors++; $display("FAIL eq_latency got %0d done=%0d want 4 done=1", obs_lat, obs_done); end
    checks++; if (cmd_count !== 8'd0) begin errors++; $display("FAIL eq_cmd_count got %0d want 0", cmd_count); end
  endtask

  task automatic test_max_cmds();
    run_op(8'd0, 8'd255, 8'd1, -1);
    checks++; if (obs_err != 1 || obs_done != 0) begin errors++; $display("FAIL max_err got err=%0d done=%0d want err=1 done=0", obs_err, obs_done); end
    checks++; if (cmd_count !== 8'd4 || c_q !== 8'd4) begin errors++; $display("FAIL max_result got cmd=%0d q=%0d want cmd=4 q=4", cmd_count, c_q); end
    checks++; if (obs_lat != 20) begin errors++; $display("FAIL max_latency got %0d want 20", obs_lat); end
  endtask

  task automatic test_stuck();
    stuck = 1'b1;
    run_op(8'd0, 8'd9, 8'd0, -1);
    stuck = 1'b0;
    checks++; if (obs_err != 1 || obs_lat != 4) begin errors++; $display("FAIL stuck_err got err=%0d lat=%0d want err=1 lat=4", obs_err, obs_lat); end
    checks++; if (cmd_count !== 8'd0) begin errors++; $display("FAIL stuck_cmd_count got %0d want 0", cmd_count); end
  endtask

  task automatic test_back_to_back();
    model(8'd10, 8'd50, 8'd16);
    run_op(8'd10, 8'd50, 8'd16, 3);
    checks++; if (!same_steps() || obs_lat != exp_lat) begin errors++; $display("FAIL busy_ignore got lat=%0d want %0d", obs_lat, exp_lat); end
    checks++; if (cmd_count !== 8'd3 || c_q !== 8'd50) begin errors++; $display("FAIL busy_ignore_result got cmd=%0d q=%0d want cmd=3 q=50", cmd_count, c_q); end
    run_op(8'd77, 8'd77, 8'd4, 4);
    checks++; if (obs_busy_after !== 1'b0) begin errors++; $display("FAIL done_cycle_start got busy=%b want 0", obs_busy_after); end
  endtask

  task automatic test_reset_mid();
    init = 8'd10; target = 8'd50; max_step = 8'd16; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({load, up, dn, busy, done, err, a_out, b_out, cmd_count} !== '0) begin
      errors++; $display("FAIL midreset_outputs got %h want 0", {load, up, dn, busy, done, err, a_out, b_out, cmd_count});
    end
    rst = 1'b0;
    @(posedge clk); #1;
    model(8'd30, 8'd20, 8'd7);
    run_op(8'd30, 8'd20, 8'd7, -1);
    checks++; if (obs_busy0 !== 1'b1 || obs_done != 1) begin errors++; $display("FAIL midreset_restart got busy=%b done=%0d want 1 1", obs_busy0, obs_done); end
    checks++; if (!same_steps() || c_q !== 8'd20 || cmd_count !== 8'd2) begin errors++; $display("FAIL midreset_result got q=%0d cmd=%0d want 20 2", c_q, cmd_count); end
  endtask

  task automatic test_random();
    logic [7:0] i, t, m;
    for (int n = 0; n < 30; n++) begin
      i = 8'($urandom_range(0, 255));
      t = (n % 3 == 0) ? i + 8'($urandom_range(0, 6)) : 8'($urandom_range(0, 255));
      m = (n % 7 == 0) ? 8'd0 : 8'($urandom_range(1, 90));
      model(i, t, m);
      run_op(i, t, m, -1);
      checks++; if (obs_done != exp_done || obs_err != 1 - exp_done) begin errors++; $display("FAIL rnd_outcome i=%0d t=%0d m=%0d got done=%0d err=%0d want done=%0d", i, t, m, obs_done, obs_err, exp_done); end
      checks++; if (!same_steps() || obs_both) begin errors++; $display("FAIL rnd_steps i=%0d t=%0d m=%0d got %0d cmds want %0d", i, t, m, obs_steps.size(), exp_steps.size()); end
      checks++; if (obs_lat != exp_lat) begin errors++; $display("FAIL rnd_latency got %0d want %0d", obs_lat, exp_lat); end
      checks++; if (int'(cmd_count) != exp_cmds || c_q !== exp_q) begin errors++; $display("FAIL rnd_result got cmd=%0d q=%0d want cmd=%0d q=%0d", cmd_count, c_q, exp_cmds, exp_q); end
      checks++; if (obs_busy0 !== 1'b1 || obs_busy_after !== 1'b0) begin errors++; $display("FAIL rnd_busy got %b%b want 10", obs_busy0, obs_busy_after); end
    end
  endtask

  initial begin
    test_reset();
    test_up_steps();
    test_single_dn();
    test_equal();
    test_max_cmds();
    test_stuck();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
